// File: rtl/imc_array_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// imc_array_phase_sequencer_if
// Command/response handshake bundle between the Wishbone-side controller
// (master) and the array phase sequencer (slave).
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : 00 WRITE, 01 READ, 10 MAC, 11 reserved
//   cmd_row             : target row for WRITE/READ
//   cmd_data            : WRITE data bits, or MAC row-enable vector
//   rsp_valid/rsp_ready : response handshake, response held until accepted
//   rsp_data, rsp_err   : captured array output, command-rejected flag
// ---------------------------------------------------------------------------
interface imc_array_phase_sequencer_if #(
    parameter int MEM_ROW   = 16,
    parameter int OUT_WIDTH = 16
);
    localparam int ROW_W = $clog2(MEM_ROW);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ROW_W-1:0]     cmd_row;
    logic [MEM_ROW-1:0]   cmd_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [OUT_WIDTH-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imc_array_phase_sequencer.sv
// ---------------------------------------------------------------------------
// imc_array_phase_sequencer
// Sequences one array command at a time (row write, row read, multi-row MAC)
// through precharge / wordline / sense / capture phases and returns the
// captured sense-amp or current-latch result on a held response channel.
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   bus (slave modport)   : command/response handshake bundle
//   SA_out                : voltage sense-amp result (READ capture)
//   IMC_out               : current-latch result (MAC capture)
//   SRAM_Din, WWL         : write data and write wordlines
//   RWL, RWLB             : read wordlines and their complement
//   WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, en : array controls
//   seq_state             : current state encoding for debug
//
// Build option: define IMC_SEQ_MAC_EN to enable MAC sequencing (IMC_out
// capture and en/PRE_CLSA/PRE_A drivers). Otherwise op 10 is rejected like
// the reserved op and those controls are tied low.
// ---------------------------------------------------------------------------
module imc_array_phase_sequencer #(
    parameter int MEM_ROW   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int PRE_CYC   = 2,
    parameter int WL_CYC    = 2,
    parameter int SA_CYC    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    imc_array_phase_sequencer_if.slave bus,
    input  logic [OUT_WIDTH-1:0]  SA_out,
    input  logic [OUT_WIDTH-1:0]  IMC_out,
    output logic [MEM_ROW-1:0]    SRAM_Din,
    output logic [MEM_ROW-1:0]    WWL,
    output logic [MEM_ROW-1:0]    RWL,
    output logic [MEM_ROW-1:0]    RWLB,
    output logic                  WE,
    output logic                  PRE_SRAM,
    output logic                  PRE_VLSA,
    output logic                  PRE_CLSA,
    output logic                  PRE_A,
    output logic                  SAEN,
    output logic                  en,
    output logic [2:0]            seq_state
);
    localparam int ROW_W = $clog2(MEM_ROW);

    localparam logic [3:0] PRE_LD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LD  = 4'(WL_CYC - 1);
    localparam logic [3:0] SA_LD  = 4'(SA_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRECH = 3'd1,
        WORD  = 3'd2,
        SENSE = 3'd3,
        CAPT  = 3'd4,
        RESP  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MAC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    op_e                  op_q, op_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [MEM_ROW-1:0]   data_q, data_d;
    logic [OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_valid_q, cmd_ready_q;

    logic [MEM_ROW-1:0]   din_q, din_d, wwl_q, wwl_d, rwl_q, rwl_d, rwlb_q, rwlb_d;
    logic                 we_q, we_d, pre_sram_q, pre_sram_d, pre_vlsa_q, pre_vlsa_d;
    logic                 saen_q, saen_d;

    logic                 cmd_legal;
    logic [MEM_ROW-1:0]   onehot;
    logic                 is_wr, is_rd, is_mac;
    logic                 ph_pre, ph_word, ph_sense, ph_capt;

`ifdef IMC_SEQ_MAC_EN
    logic en_q, en_d, pre_clsa_q, pre_clsa_d, pre_a_q, pre_a_d;
    assign cmd_legal = (bus.cmd_op != OP_RSVD);
`else
    logic imc_unused;
    assign imc_unused = ^IMC_out;
    assign cmd_legal  = (bus.cmd_op == OP_WRITE) || (bus.cmd_op == OP_READ);
`endif

    // Next-state, phase counter and response register logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        row_d      = row_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = op_e'(bus.cmd_op);
                    row_d  = bus.cmd_row;
                    data_d = bus.cmd_data;
                    if (cmd_legal) begin
                        state_d = PRECH;
                        cnt_d   = PRE_LD;
                    end else begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end
            PRECH: begin
                if (cnt_q == '0) begin
                    state_d = WORD;
                    cnt_d   = WL_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WORD: begin
                if (cnt_q == '0) begin
                    if (op_q == OP_WRITE) begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = '0;
                    end else begin
                        state_d = SENSE;
                        cnt_d   = SA_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SENSE: begin
                if (cnt_q == '0) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPT: begin
                state_d   = RESP;
                rsp_err_d = 1'b0;
`ifdef IMC_SEQ_MAC_EN
                rsp_data_d = (op_q == OP_MAC) ? IMC_out : SA_out;
`else
                rsp_data_d = SA_out;
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d    = IDLE;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array outputs are decoded from the upcoming state so that the
    // registered outputs switch exactly on phase-boundary edges.
    always_comb begin
        onehot   = MEM_ROW'(1) << row_d;
        is_wr    = (op_d == OP_WRITE);
        is_rd    = (op_d == OP_READ);
`ifdef IMC_SEQ_MAC_EN
        is_mac   = (op_d == OP_MAC);
`else
        is_mac   = 1'b0;
`endif
        ph_pre   = (state_d == PRECH);
        ph_word  = (state_d == WORD);
        ph_sense = (state_d == SENSE);
        ph_capt  = (state_d == CAPT);

        pre_sram_d = ph_pre && (is_wr || is_rd);
        pre_vlsa_d = ph_pre && is_rd;
        we_d       = ph_word && is_wr;
        wwl_d      = we_d ? onehot : '0;
        din_d      = we_d ? data_d : '0;
        rwl_d      = '0;
        rwlb_d     = '0;
        if ((ph_word || ph_sense) && is_rd) begin
            rwl_d  = onehot;
            rwlb_d = ~onehot;
        end else if ((ph_word || ph_sense) && is_mac) begin
            rwl_d  = data_d;
            rwlb_d = ~data_d;
        end
        saen_d = (ph_sense || ph_capt) && (is_rd || is_mac);
`ifdef IMC_SEQ_MAC_EN
        en_d       = is_mac && (ph_pre || ph_word || ph_sense || ph_capt);
        pre_clsa_d = ph_pre && is_mac;
        pre_a_d    = ph_pre && is_mac;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_WRITE;
            row_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            din_q       <= '0;
            wwl_q       <= '0;
            rwl_q       <= '0;
            rwlb_q      <= '0;
            we_q        <= 1'b0;
            pre_sram_q  <= 1'b0;
            pre_vlsa_q  <= 1'b0;
            saen_q      <= 1'b0;
`ifdef IMC_SEQ_MAC_EN
            en_q        <= 1'b0;
            pre_clsa_q  <= 1'b0;
            pre_a_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            row_q       <= row_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= (state_d == RESP);
            cmd_ready_q <= (state_d == IDLE);
            din_q       <= din_d;
            wwl_q       <= wwl_d;
            rwl_q       <= rwl_d;
            rwlb_q      <= rwlb_d;
            we_q        <= we_d;
            pre_sram_q  <= pre_sram_d;
            pre_vlsa_q  <= pre_vlsa_d;
            saen_q      <= saen_d;
`ifdef IMC_SEQ_MAC_EN
            en_q        <= en_d;
            pre_clsa_q  <= pre_clsa_d;
            pre_a_q     <= pre_a_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    assign SRAM_Din  = din_q;
    assign WWL       = wwl_q;
    assign RWL       = rwl_q;
    assign RWLB      = rwlb_q;
    assign WE        = we_q;
    assign PRE_SRAM  = pre_sram_q;
    assign PRE_VLSA  = pre_vlsa_q;
    assign SAEN      = saen_q;
    assign seq_state = state_q;
`ifdef IMC_SEQ_MAC_EN
    assign en        = en_q;
    assign PRE_CLSA  = pre_clsa_q;
    assign PRE_A     = pre_a_q;
`else
    assign en        = 1'b0;
    assign PRE_CLSA  = 1'b0;
    assign PRE_A     = 1'b0;
`endif
endmodule

// File: tb/tb_imc_array_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_imc_array_phase_sequencer
// Per-cycle trace checks of the phase sequencer against a timeline model:
// every command's expected outputs are derived from the phase lengths and
// the period index counted from the accept edge.
// ---------------------------------------------------------------------------
module tb_imc_array_phase_sequencer;
    localparam int MEM_ROW   = 16;
    localparam int OUT_WIDTH = 16;
    localparam int PRE       = 2;
    localparam int WL        = 2;
    localparam int SA        = 1;
    localparam int MAXL      = 32;
`ifdef IMC_SEQ_MAC_EN
    localparam bit MAC_ON = 1'b1;
`else
    localparam bit MAC_ON = 1'b0;
`endif

    typedef struct packed {
        logic        cmd_ready;
        logic        rsp_valid;
        logic        rsp_err;
        logic [15:0] rsp_data;
        logic [2:0]  seq;
        logic [15:0] din;
        logic [15:0] wwl;
        logic [15:0] rwl;
        logic [15:0] rwlb;
        logic        we;
        logic        pre_sram;
        logic        pre_vlsa;
        logic        pre_clsa;
        logic        pre_a;
        logic        saen;
        logic        en;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] SA_out, IMC_out;
    logic [15:0] SRAM_Din, WWL, RWL, RWLB;
    logic        WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, en;
    logic [2:0]  seq_state;

    int    n_cmp = 0;
    int    n_bad = 0;
    snap_t obs [0:MAXL-1];
    int    trace_len;

    imc_array_phase_sequencer_if #(.MEM_ROW(MEM_ROW), .OUT_WIDTH(OUT_WIDTH)) bus ();

    imc_array_phase_sequencer #(
        .MEM_ROW(MEM_ROW), .OUT_WIDTH(OUT_WIDTH),
        .PRE_CYC(PRE), .WL_CYC(WL), .SA_CYC(SA)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .SA_out(SA_out), .IMC_out(IMC_out),
        .SRAM_Din(SRAM_Din), .WWL(WWL), .RWL(RWL), .RWLB(RWLB),
        .WE(WE), .PRE_SRAM(PRE_SRAM), .PRE_VLSA(PRE_VLSA),
        .PRE_CLSA(PRE_CLSA), .PRE_A(PRE_A), .SAEN(SAEN), .en(en),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic snap_t sample();
        snap_t s;
        s.cmd_ready = bus.cmd_ready;
        s.rsp_valid = bus.rsp_valid;
        s.rsp_err   = bus.rsp_err;
        s.rsp_data  = bus.rsp_data;
        s.seq       = seq_state;
        s.din       = SRAM_Din;
        s.wwl       = WWL;
        s.rwl       = RWL;
        s.rwlb      = RWLB;
        s.we        = WE;
        s.pre_sram  = PRE_SRAM;
        s.pre_vlsa  = PRE_VLSA;
        s.pre_clsa  = PRE_CLSA;
        s.pre_a     = PRE_A;
        s.saen      = SAEN;
        s.en        = en;
        return s;
    endfunction

    function automatic snap_t idle_exp();
        snap_t s = '0;
        s.cmd_ready = 1'b1;
        return s;
    endfunction

    function automatic bit is_legal(input int op);
        return (op == 0) || (op == 1) || (op == 2 && MAC_ON);
    endfunction

    // First period (counted from the accept edge) in which rsp_valid is high
    function automatic int resp_start(input int op);
        if (!is_legal(op)) return 1;
        if (op == 0) return PRE + WL + 1;
        return PRE + WL + SA + 2;
    endfunction

    // Expected outputs during period k after the accept edge
    function automatic snap_t model_at(input int op, input int row, input logic [15:0] data,
                                       input logic [15:0] sa, input logic [15:0] imc,
                                       input int hold, input int k);
        snap_t       e = '0;
        int          rs = resp_start(op);
        int          ph;
        logic [15:0] oh = 16'd1 << row;
        if (k > rs + hold) begin
            e.cmd_ready = 1'b1;
            return e;
        end
        if (k >= rs) begin
            e.rsp_valid = 1'b1;
            e.seq       = 3'd5;
            e.rsp_err   = !is_legal(op);
            if (is_legal(op) && op == 1) e.rsp_data = sa;
            else if (is_legal(op) && op == 2) e.rsp_data = imc;
            return e;
        end
        if (k <= PRE) ph = 1;
        else if (k <= PRE + WL) ph = 2;
        else if (k <= PRE + WL + SA) ph = 3;
        else ph = 4;
        e.seq = 3'(ph);
        case (op)
            0: begin
                e.pre_sram = (ph == 1);
                if (ph == 2) begin
                    e.wwl = oh;
                    e.we  = 1'b1;
                    e.din = data;
                end
            end
            1: begin
                e.pre_sram = (ph == 1);
                e.pre_vlsa = (ph == 1);
                if (ph == 2 || ph == 3) begin
                    e.rwl  = oh;
                    e.rwlb = ~oh;
                end
                e.saen = (ph >= 3);
            end
            default: begin
                e.en       = 1'b1;
                e.pre_clsa = (ph == 1);
                e.pre_a    = (ph == 1);
                if (ph == 2 || ph == 3) begin
                    e.rwl  = data;
                    e.rwlb = ~data;
                end
                e.saen = (ph >= 3);
            end
        endcase
        return e;
    endfunction

    // Offer one command at the current negedge and record the output trace
    // until the sequencer is back in IDLE. SA_out/IMC_out carry the wanted
    // value only in the capture period, random noise otherwise.
    task automatic collect(input int op, input int row, input logic [15:0] data,
                           input logic [15:0] sa, input logic [15:0] imc, input int hold);
        int vcnt = 0;
        int cap  = resp_start(op) - 1;
        trace_len = resp_start(op) + hold + 1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_row   = 4'(row);
        bus.cmd_data  = data;
        bus.rsp_ready = 1'b0;
        SA_out        = 16'($urandom);
        IMC_out       = 16'($urandom);
        @(posedge clk);
        for (int k = 1; k <= trace_len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = 2'($urandom);
                bus.cmd_row   = 4'($urandom);
                bus.cmd_data  = 16'($urandom);
            end
            obs[k] = sample();
            if (obs[k].rsp_valid) vcnt++;
            bus.rsp_ready = obs[k].rsp_valid && (vcnt > hold);
            SA_out  = (k == cap) ? sa  : 16'($urandom);
            IMC_out = (k == cap) ? imc : 16'($urandom);
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_row   = 4'd1;
        bus.cmd_data  = 16'hFFFF;
        bus.rsp_ready = 1'b0;
        SA_out        = 16'h0;
        IMC_out       = 16'h0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (sample() !== idle_exp()) begin
                n_bad++;
                $display("FAIL reset_hold got=%h exp=%h", sample(), idle_exp());
            end
        end
        bus.cmd_valid = 1'b0;
        reset_n       = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sample() !== idle_exp()) begin
            n_bad++;
            $display("FAIL reset_release got=%h exp=%h", sample(), idle_exp());
        end
    endtask

    task automatic test_write();
        logic [15:0] sa  = 16'($urandom);
        logic [15:0] imc = 16'($urandom);
        collect(0, 5, 16'hA5A5, sa, imc, 0);
        for (int k = 1; k <= trace_len; k++) begin
            snap_t e = model_at(0, 5, 16'hA5A5, sa, imc, 0, k);
            n_cmp++;
            if (obs[k] !== e) begin
                n_bad++;
                $display("FAIL write k=%0d got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_read_hold();
        logic [15:0] d   = 16'($urandom);
        logic [15:0] imc = 16'($urandom);
        collect(1, 3, d, 16'h1234, imc, 3);
        for (int k = 1; k <= trace_len; k++) begin
            snap_t e = model_at(1, 3, d, 16'h1234, imc, 3, k);
            n_cmp++;
            if (obs[k] !== e) begin
                n_bad++;
                $display("FAIL read_hold k=%0d got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_mac();
        int          row = int'($urandom_range(0, 15));
        logic [15:0] sa  = 16'($urandom);
        collect(2, row, 16'h00FF, sa, 16'h0042, 0);
        for (int k = 1; k <= trace_len; k++) begin
            snap_t e = model_at(2, row, 16'h00FF, sa, 16'h0042, 0, k);
            n_cmp++;
            if (obs[k] !== e) begin
                n_bad++;
                $display("FAIL mac k=%0d got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_reserved();
        int          row = int'($urandom_range(0, 15));
        logic [15:0] d   = 16'($urandom);
        logic [15:0] sa  = 16'($urandom);
        logic [15:0] imc = 16'($urandom);
        collect(3, row, d, sa, imc, 1);
        for (int k = 1; k <= trace_len; k++) begin
            snap_t e = model_at(3, row, d, sa, imc, 1, k);
            n_cmp++;
            if (obs[k] !== e) begin
                n_bad++;
                $display("FAIL reserved k=%0d got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d = 16'($urandom);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_row   = 4'd9;
        bus.cmd_data  = d;
        SA_out        = 16'($urandom);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            snap_t e = model_at(1, 9, d, 16'h0, 16'h0, 0, k);
            @(negedge clk);
            if (k == 1) bus.cmd_valid = 1'b0;
            n_cmp++;
            if (sample() !== e) begin
                n_bad++;
                $display("FAIL abort_pre k=%0d got=%h exp=%h", k, sample(), e);
            end
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sample() !== idle_exp()) begin
            n_bad++;
            $display("FAIL abort_reset got=%h exp=%h", sample(), idle_exp());
        end
        reset_n = 1'b1;
        collect(0, 12, 16'h5A0F, 16'h0, 16'h0, 1);
        for (int k = 1; k <= trace_len; k++) begin
            snap_t e = model_at(0, 12, 16'h5A0F, 16'h0, 16'h0, 1, k);
            n_cmp++;
            if (obs[k] !== e) begin
                n_bad++;
                $display("FAIL abort_write k=%0d got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 12; n++) begin
            int          op   = int'($urandom_range(0, 3));
            int          row  = int'($urandom_range(0, 15));
            int          hold = int'($urandom_range(0, 2));
            logic [15:0] d    = 16'($urandom);
            logic [15:0] sa   = 16'($urandom);
            logic [15:0] imc  = 16'($urandom);
            collect(op, row, d, sa, imc, hold);
            for (int k = 1; k <= trace_len; k++) begin
                snap_t e = model_at(op, row, d, sa, imc, hold, k);
                n_cmp++;
                if (obs[k] !== e) begin
                    n_bad++;
                    $display("FAIL b2b n=%0d op=%0d k=%0d got=%h exp=%h", n, op, k, obs[k], e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_mac();
        test_reserved();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
